// File: rtl/swipt_pkg.sv
// Shared widths, defaults and phase codes for the SWIPT transmitter sequencer.
package swipt_pkg;

    localparam int FREQ_W = 20;
    localparam int DUTY_W = 12;
    localparam int MEAS_W = 20;

    localparam logic [FREQ_W-1:0] START_FREQ  = 20'h88B8;
    localparam logic [DUTY_W-1:0] START_DUTY  = 12'hC8;
    localparam logic [FREQ_W-1:0] FREQ_MIN    = 20'h4E20;
    localparam logic [FREQ_W-1:0] FREQ_MAX    = 20'hEA60;
    localparam logic [MEAS_W-1:0] MEAS_CYCLES = 20'hF4240;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_FREQ = 2'b01,
        PH_MEAS = 2'b10,
        PH_DATA = 2'b11
    } phase_t;

endpackage

// File: rtl/meas_window_timer.sv
// Timed mean-current window: start arms it, active is high for exactly MEAS_CYCLES cycles, then done pulses once.
// Registered outputs, one cycle after start; abort/rst drop active next cycle with no done; start while armed is ignored.
module meas_window_timer #(
    parameter logic [swipt_pkg::MEAS_W-1:0] MEAS_CYCLES = swipt_pkg::MEAS_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_abort,
    output logic o_active,
    output logic o_done,
    output logic o_expire
);
    import swipt_pkg::*;

    logic [MEAS_W-1:0] r_cnt;
    logic              r_armed;
    logic              r_active;
    logic              r_done;

    // Counter sits at MEAS_CYCLES whenever idle, so arming needs no separate load.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            r_cnt    <= MEAS_CYCLES;
            r_armed  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_armed) begin
                if (r_cnt != '0) begin
                    r_active <= 1'b1;
                    r_cnt    <= r_cnt - 1'b1;
                end else begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_cnt    <= MEAS_CYCLES;
                    r_armed  <= 1'b0;
                end
            end else if (i_start) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_active = r_active;
    assign o_done   = r_done;
    // High on the cycle whose edge ends the window; lets the parent switch phase in step with done.
    assign o_expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/swipt_sequencer.sv
// SWIPT phase controller: IDLE -> FREQ_OPT -> MEASURE -> DATA, owning freq/duty words for the output stage.
// All outputs registered (1-cycle latency); no backpressure, heartbeat loss and comms override preempt every phase.
module swipt_sequencer #(
    parameter int                 FREQ_W      = swipt_pkg::FREQ_W,
    parameter int                 DUTY_W      = swipt_pkg::DUTY_W,
    parameter logic [FREQ_W-1:0]  START_FREQ  = swipt_pkg::START_FREQ,
    parameter logic [DUTY_W-1:0]  START_DUTY  = swipt_pkg::START_DUTY,
    parameter logic [FREQ_W-1:0]  FREQ_MIN    = swipt_pkg::FREQ_MIN,
    parameter logic [FREQ_W-1:0]  FREQ_MAX    = swipt_pkg::FREQ_MAX,
    parameter logic [swipt_pkg::MEAS_W-1:0] MEAS_CYCLES = swipt_pkg::MEAS_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_swipt_alive,
    input  logic              i_comms_ctrl,
    input  logic [FREQ_W-1:0] i_comms_freq,
    input  logic [DUTY_W-1:0] i_comms_duty,
    input  logic [FREQ_W-1:0] i_freq_new,
    input  logic [FREQ_W-1:0] i_freq_best,
    input  logic              i_freq_done,
    input  logic              i_meas_req,
    input  logic              i_rescan_req,
    output logic [1:0]        o_program,
    output logic [FREQ_W-1:0] o_freq,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_measure,
    output logic              o_meas_done
);
    import swipt_pkg::*;

    phase_t            r_program;
    logic [FREQ_W-1:0] r_freq;
    logic [DUTY_W-1:0] r_duty;
    logic              r_dmeas;

    logic w_start;
    logic w_abort;
    logic w_expire;
    logic w_measure;
    logic w_meas_done;

    function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] v);
        if (v < FREQ_MIN)
            return FREQ_MIN;
        else if (v > FREQ_MAX)
            return FREQ_MAX;
        return v;
    endfunction

    // Rescan wins over a same-cycle meas_req; a re-measure only starts when none is running.
    assign w_abort = !i_swipt_alive || i_comms_ctrl || (r_program == PH_DATA && i_rescan_req);
    assign w_start = (r_program == PH_FREQ && i_freq_done) ||
                     (r_program == PH_DATA && i_meas_req && !r_dmeas && !i_rescan_req);

    meas_window_timer #(
        .MEAS_CYCLES (MEAS_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_start),
        .i_abort  (w_abort),
        .o_active (w_measure),
        .o_done   (w_meas_done),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_swipt_alive) begin
            r_program <= PH_IDLE;
            r_freq    <= START_FREQ;
            r_duty    <= START_DUTY;
            r_dmeas   <= 1'b0;
        end else if (i_comms_ctrl) begin
            r_program <= PH_IDLE;
            r_freq    <= i_comms_freq;
            r_duty    <= i_comms_duty;
            r_dmeas   <= 1'b0;
        end else begin
            case (r_program)
                PH_IDLE: r_program <= PH_FREQ;
                PH_FREQ: begin
                    if (i_freq_done) begin
                        r_freq    <= clamp_freq(i_freq_best);
                        r_program <= PH_MEAS;
                    end else begin
                        r_freq <= clamp_freq(i_freq_new);
                    end
                end
                PH_MEAS: begin
                    if (w_expire)
                        r_program <= PH_DATA;
                end
                PH_DATA: begin
                    if (i_rescan_req) begin
                        r_program <= PH_FREQ;
                        r_dmeas   <= 1'b0;
                    end else if (r_dmeas && w_expire) begin
                        r_dmeas <= 1'b0;
                    end else if (i_meas_req && !r_dmeas) begin
                        r_dmeas <= 1'b1;
                    end
                end
                default: r_program <= PH_IDLE;
            endcase
        end
    end

    assign o_program   = r_program;
    assign o_freq      = r_freq;
    assign o_duty      = r_duty;
    assign o_measure   = w_measure;
    assign o_meas_done = w_meas_done;

endmodule

// File: tb/tb_swipt_sequencer.sv
// Directed scenarios followed by randomized stimulus, all checked against a behavioural phase/window model.
module tb_swipt_sequencer;

    localparam int MC   = 8;
    localparam int FMIN = 100;
    localparam int FMAX = 1000;
    localparam int SF   = 'h88B8;
    localparam int SD   = 'hC8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alive = 1'b0;
    logic        comms = 1'b0;
    logic        fd = 1'b0;
    logic        mreq = 1'b0;
    logic        rreq = 1'b0;
    logic [19:0] cf = '0;
    logic [11:0] cd = '0;
    logic [19:0] fnew = '0;
    logic [19:0] fbest = '0;

    logic [1:0]  prog;
    logic [19:0] freq;
    logic [11:0] duty;
    logic        meas;
    logic        mdone;

    int n_checks = 0;
    int n_errors = 0;
    int hi_cnt = 0;
    int done_cnt = 0;

    // Reference model: phase, output words, and position inside the current window (-1 = none).
    int m_prog = 0;
    int m_freq = SF;
    int m_duty = SD;
    int m_win  = -1;
    bit m_meas = 1'b0;
    bit m_done = 1'b0;
    bit m_dmeas = 1'b0;

    always #5 clk = ~clk;

    swipt_sequencer #(
        .MEAS_CYCLES (20'd8),
        .FREQ_MIN    (20'd100),
        .FREQ_MAX    (20'd1000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_swipt_alive (alive),
        .i_comms_ctrl  (comms),
        .i_comms_freq  (cf),
        .i_comms_duty  (cd),
        .i_freq_new    (fnew),
        .i_freq_best   (fbest),
        .i_freq_done   (fd),
        .i_meas_req    (mreq),
        .i_rescan_req  (rreq),
        .o_program     (prog),
        .o_freq        (freq),
        .o_duty        (duty),
        .o_measure     (meas),
        .o_meas_done   (mdone)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampf(input int v);
        if (v < FMIN) return FMIN;
        if (v > FMAX) return FMAX;
        return v;
    endfunction

    task automatic model_step();
        bit wend;
        if (rst || !alive) begin
            m_prog = 0; m_freq = SF; m_duty = SD;
            m_meas = 0; m_done = 0; m_win = -1; m_dmeas = 0;
        end else if (comms) begin
            m_prog = 0; m_freq = int'(cf); m_duty = int'(cd);
            m_meas = 0; m_done = 0; m_win = -1; m_dmeas = 0;
        end else begin
            wend = 1'b0;
            m_meas = 0;
            m_done = 0;
            if (m_win >= 0) begin
                if (m_win < MC) begin
                    m_meas = 1;
                    m_win++;
                end else begin
                    m_done = 1;
                    m_win = -1;
                    wend = 1'b1;
                end
            end
            case (m_prog)
                0: m_prog = 1;
                1: begin
                    if (fd) begin
                        m_freq = clampf(int'(fbest));
                        m_prog = 2;
                        m_win = 0;
                    end else begin
                        m_freq = clampf(int'(fnew));
                    end
                end
                2: if (wend) m_prog = 3;
                default: begin
                    if (rreq) begin
                        m_prog = 1; m_meas = 0; m_done = 0; m_win = -1; m_dmeas = 0;
                    end else if (wend) begin
                        m_dmeas = 0;
                    end else if (mreq && !m_dmeas) begin
                        m_dmeas = 1;
                        m_win = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("program", {30'd0, prog}, m_prog);
        check_eq("freq", {12'd0, freq}, m_freq);
        check_eq("duty", {20'd0, duty}, m_duty);
        check_eq("measure", {31'd0, meas}, {31'd0, m_meas});
        check_eq("meas_done", {31'd0, mdone}, {31'd0, m_done});
        if (meas) hi_cnt++;
        if (mdone) done_cnt++;
    endtask

    initial begin
        int comms_left;
        comms_left = 0;

        // Reset state
        rst = 1'b1;
        tick();
        check_eq("rst_program", {30'd0, prog}, 0);
        check_eq("rst_freq", {12'd0, freq}, SF);
        check_eq("rst_duty", {20'd0, duty}, SD);
        check_eq("rst_measure", {31'd0, meas}, 0);

        // Nominal bring-up into DATA
        rst = 1'b0; alive = 1'b1; fnew = 20'd500;
        tick();
        check_eq("idle_to_freq", {30'd0, prog}, 1);
        repeat (4) tick();
        check_eq("freq_tracks", {12'd0, freq}, 500);
        hi_cnt = 0; done_cnt = 0;
        fd = 1'b1; fbest = 20'd600;
        tick();
        fd = 1'b0;
        check_eq("best_freq", {12'd0, freq}, 600);
        check_eq("enter_meas", {30'd0, prog}, 2);
        repeat (9) tick();
        check_eq("enter_data", {30'd0, prog}, 3);
        check_eq("meas_len", hi_cnt, MC);
        check_eq("meas_done_cnt", done_cnt, 1);

        // Clamp during re-optimisation
        rreq = 1'b1;
        tick();
        rreq = 1'b0;
        check_eq("rescan_prog", {30'd0, prog}, 1);
        fnew = 20'd50;
        tick();
        check_eq("clamp_low", {12'd0, freq}, 100);
        fnew = 20'd2000;
        tick();
        check_eq("clamp_high", {12'd0, freq}, 1000);
        fd = 1'b1;
        tick();
        fd = 1'b0;
        repeat (9) tick();
        check_eq("back_to_data", {30'd0, prog}, 3);

        // In-DATA re-measure, second request inside the window ignored
        hi_cnt = 0; done_cnt = 0;
        mreq = 1'b1;
        tick();
        mreq = 1'b0;
        repeat (3) tick();
        mreq = 1'b1;
        tick();
        mreq = 1'b0;
        repeat (10) tick();
        check_eq("dmeas_prog", {30'd0, prog}, 3);
        check_eq("dmeas_len", hi_cnt, MC);
        check_eq("dmeas_done_cnt", done_cnt, 1);

        // Simultaneous rescan and meas_req
        rreq = 1'b1; mreq = 1'b1;
        tick();
        rreq = 1'b0; mreq = 1'b0;
        check_eq("rescan_wins_prog", {30'd0, prog}, 1);
        tick();
        check_eq("rescan_wins_meas", {31'd0, meas}, 0);

        // Comms override mid-MEASURE
        fd = 1'b1;
        tick();
        fd = 1'b0;
        repeat (3) tick();
        done_cnt = 0;
        comms = 1'b1; cf = 20'h9C40; cd = 12'h064;
        tick();
        check_eq("comms_freq", {12'd0, freq}, 'h9C40);
        check_eq("comms_duty", {20'd0, duty}, 'h064);
        check_eq("comms_meas", {31'd0, meas}, 0);
        check_eq("comms_prog", {30'd0, prog}, 0);
        comms = 1'b0;
        tick();
        check_eq("comms_release", {30'd0, prog}, 1);
        repeat (10) tick();
        check_eq("comms_no_done", done_cnt, 0);

        // Heartbeat loss at count 3 of a window
        fd = 1'b1;
        tick();
        fd = 1'b0;
        repeat (3) tick();
        alive = 1'b0;
        tick();
        alive = 1'b1;
        check_eq("hb_prog", {30'd0, prog}, 0);
        check_eq("hb_freq", {12'd0, freq}, SF);
        check_eq("hb_duty", {20'd0, duty}, SD);
        check_eq("hb_meas", {31'd0, meas}, 0);
        tick();
        check_eq("hb_restart", {30'd0, prog}, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            alive = ($urandom_range(0, 149) != 0);
            if (comms_left > 0)
                comms_left--;
            else if ($urandom_range(0, 99) == 0)
                comms_left = $urandom_range(1, 6);
            comms = (comms_left > 0);
            cf    = 20'($urandom);
            cd    = 12'($urandom);
            fd    = ($urandom_range(0, 7) == 0);
            fnew  = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 1200));
            fbest = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 1200));
            mreq  = ($urandom_range(0, 9) == 0);
            rreq  = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/swipt_sequencer.md
Name: swipt_sequencer

Overview:
- Top-level phase controller for the SWIPT transmitter.
- Owns the frequency and duty words that drive the SWIPT output stage.
- Sequences three phases in order: frequency optimisation, a timed mean-current measurement window, then data/power operation.
- Handles the comms override, loss of heartbeat, and re-measurement or re-scan requests from the data block.

Parameters:
- FREQ_W, 20, width of frequency word
- DUTY_W, 12, width of duty/pulse-length word l
- START_FREQ, 20'h88B8, default frequency (35 kHz)
- START_DUTY, 12'hC8, default duty word
- FREQ_MIN, 20'h4E20, lowest frequency accepted from the optimiser
- FREQ_MAX, 20'hEA60, highest frequency accepted from the optimiser
- MEAS_CYCLES, 20'hF4240, measurement window length in clk cycles (must be ≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- swipt_alive  in  1  heartbeat-valid from the heartbeat block
- comms_ctrl  in  1  comms override enable
- comms_freq  in  FREQ_W  override frequency
- comms_duty  in  DUTY_W  override duty
- freq_new  in  FREQ_W  per-cycle candidate from the frequency optimiser
- freq_best  in  FREQ_W  final result from the frequency optimiser
- freq_done  in  1  optimiser finished (level)
- meas_req  in  1  data block requests a fresh measurement (1-cycle pulse)
- rescan_req  in  1  data block requests re-optimisation (1-cycle pulse)
- program  out  2  phase code: 00 IDLE, 01 FREQ_OPT, 10 MEASURE, 11 DATA
- freq  out  FREQ_W  frequency to the output stage
- duty  out  DUTY_W  duty to the output stage
- measure  out  1  enables the mean-current accumulator
- meas_done  out  1  1-cycle pulse at the end of each measurement window

Behaviour:
- All outputs are registered.
- Priority per cycle: rst > !swipt_alive > comms_ctrl > phase logic.
- Reset state, also applied on any cycle with swipt_alive=0:
  - program=00, freq=START_FREQ, duty=START_DUTY
  - measure=0, meas_done=0
  - counter=MEAS_CYCLES, dmeas flag=0
- comms_ctrl=1: each cycle freq<=comms_freq and duty<=comms_duty, both unclamped.
  - Also program<=00, measure<=0, counter reloaded, dmeas cleared.
  - On release, the sequence restarts from IDLE.
- IDLE: 1 cycle, then FREQ_OPT. duty is held throughout all phases.
- FREQ_OPT:
  - While freq_done=0: freq<=clamp(freq_new, FREQ_MIN, FREQ_MAX).
  - On the cycle freq_done=1: freq<=clamp(freq_best), program<=10, counter<=MEAS_CYCLES.
- MEASURE:
  - While counter≠0: measure<=1, counter decrements.
  - When counter==0: measure<=0, meas_done<=1 for one cycle, counter<=MEAS_CYCLES, program<=11.
  - measure is therefore high for exactly MEAS_CYCLES consecutive cycles.
  - meas_req and rescan_req are ignored in this phase.
- DATA:
  - rescan_req=1: program<=01. Any measurement in progress is aborted (measure<=0, counter reloaded, dmeas cleared).
  - Else meas_req=1 with dmeas=0: dmeas<=1 and the same timed window runs while program stays 11; meas_done pulses at its end, then dmeas<=0.
  - meas_req while dmeas=1 is ignored; no queueing.
  - Simultaneous rescan_req and meas_req: rescan wins and meas_req is dropped.
- Clamp: values below FREQ_MIN become FREQ_MIN; values above FREQ_MAX become FREQ_MAX; comparison is unsigned.
- Counter is MEAS_W=20 bits, down-counting. It never wraps: decrement occurs only when ≠0.
- rst or swipt_alive loss mid-window: measure drops the next cycle and no meas_done is issued.

Decomposition:
- Package swipt_pkg holds:
  - phase codes PH_IDLE/PH_FREQ/PH_MEAS/PH_DATA
  - START_FREQ, START_DUTY, MEAS_CYCLES defaults
  - FREQ_W/DUTY_W
- One sub-module: meas_window_timer.
  - Inputs: clk, rst, start, abort.
  - Outputs: active (=measure), done (pulse).
  - Parameter: MEAS_CYCLES.
  - Used for both the MEASURE phase and in-DATA re-measurements.

Test Plan (MEAS_CYCLES=8, FREQ_MIN=100, FREQ_MAX=1000):
- Reset release, freq_new=500, freq_done low 5 cycles then high with freq_best=600 -> program 00→01 after 1 cycle; freq tracks 500; freq=600 and program=10 the cycle after freq_done; measure high exactly 8 cycles; meas_done pulses once; program=11.
- freq_new=50 then 2000 during FREQ_OPT -> freq=100 then 1000.
- In DATA, meas_req pulse -> program stays 11; measure high 8 cycles; one meas_done; a second meas_req during the window is ignored (single pulse total).
- In DATA, rescan_req and meas_req in the same cycle -> program=01 next cycle; measure stays 0.
- comms_ctrl=1 with comms_freq=20'h9C40, comms_duty=12'h64 mid-MEASURE -> next cycle freq=9C40, duty=064, measure=0, program=00, no meas_done; release → IDLE→FREQ_OPT.
- swipt_alive=0 for 1 cycle at count 3 of a window -> all outputs at reset values next cycle; sequence restarts from IDLE.
